// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder: ALU operation codes and the
// base-ISA major opcodes that the decoder recognises.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SLL   = 4'b0001,
      ALU_SLT   = 4'b0010,
      ALU_SLTU  = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SRL   = 4'b0101,
      ALU_OR    = 4'b0110,
      ALU_AND   = 4'b0111,
      ALU_SUB   = 4'b1000,
      ALU_SRA   = 4'b1101,
      ALU_PASSB = 4'b1111
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder: maps opcode/func3/func7 to a 4-bit ALU operation and an
// illegal flag, with an optional one-cycle output register.
module alu_dec
   import alu_pkg::*;
#(
   parameter int REG_OUT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output logic [3:0] alu_control,
   output logic       valid_out,
   output logic       illegal
);

   alu_op_e w_dec_op;
   logic    w_dec_bad;
   alu_op_e w_op;
   logic    w_illegal;

   always_comb begin
      w_dec_op  = ALU_ADD;
      w_dec_bad = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (func7 == F7_BASE)                       w_dec_op = alu_op_e'({1'b0, func3});
            else if (func7 == F7_ALT && func3 == 3'b000) w_dec_op = ALU_SUB;
            else if (func7 == F7_ALT && func3 == 3'b101) w_dec_op = ALU_SRA;
            else                                         w_dec_bad = 1'b1;
         end
         OPC_OP_IMM: begin
            case (func3)
               3'b001: begin
                  if (func7 == F7_BASE) w_dec_op = ALU_SLL;
                  else                  w_dec_bad = 1'b1;
               end
               3'b101: begin
                  if (func7 == F7_BASE)     w_dec_op = ALU_SRL;
                  else if (func7 == F7_ALT) w_dec_op = ALU_SRA;
                  else                      w_dec_bad = 1'b1;
               end
               // func7 is immediate data here, so ADDI never becomes SUB
               default: w_dec_op = alu_op_e'({1'b0, func3});
            endcase
         end
         OPC_BRANCH: begin
            case (func3)
               3'b000, 3'b001: w_dec_op = ALU_SUB;
               3'b100, 3'b101: w_dec_op = ALU_SLT;
               3'b110, 3'b111: w_dec_op = ALU_SLTU;
               default:        w_dec_bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            case (func3)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_dec_op = ALU_ADD;
               default:                                w_dec_bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            case (func3)
               3'b000, 3'b001, 3'b010: w_dec_op = ALU_ADD;
               default:                w_dec_bad = 1'b1;
            endcase
         end
         OPC_JALR: begin
            if (func3 == 3'b000) w_dec_op = ALU_ADD;
            else                 w_dec_bad = 1'b1;
         end
         OPC_JAL, OPC_AUIPC: w_dec_op = ALU_ADD;
         OPC_LUI:            w_dec_op = ALU_PASSB;
         default:            w_dec_bad = 1'b1;
      endcase
   end

   // Illegal or idle slots always present ADD so downstream sees a benign op
   always_comb begin
      w_illegal = valid_in & w_dec_bad;
      w_op      = (valid_in && !w_dec_bad) ? w_dec_op : ALU_ADD;
   end

   generate
      if (REG_OUT != 0) begin : g_reg
         logic [3:0] r_alu_control;
         logic       r_valid_out;
         logic       r_illegal;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_alu_control <= ALU_ADD;
               r_valid_out   <= 1'b0;
               r_illegal     <= 1'b0;
            end else begin
               r_alu_control <= w_op;
               r_valid_out   <= valid_in;
               r_illegal     <= w_illegal;
            end
         end

         assign alu_control = r_alu_control;
         assign valid_out   = r_valid_out;
         assign illegal     = r_illegal;
      end else begin : g_comb
         logic w_unused;
         assign w_unused    = clk ^ reset;
         assign alu_control = w_op;
         assign valid_out   = valid_in;
         assign illegal     = w_illegal;
      end
   endgenerate

endmodule

// File: tb/tb_alu_dec.sv
// Self-checking bench for alu_dec: registered and combinational instances share
// stimulus; directed table, hand sequences and random vectors vs a reference model.
module tb_alu_dec;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;

   logic [3:0] r_ctrl, c_ctrl;
   logic       r_vo, c_vo, r_ill, c_ill;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_dec #(.REG_OUT(1)) u_reg (
      .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
      .func3(func3), .func7(func7),
      .alu_control(r_ctrl), .valid_out(r_vo), .illegal(r_ill)
   );

   alu_dec #(.REG_OUT(0)) u_comb (
      .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode),
      .func3(func3), .func7(func7),
      .alu_control(c_ctrl), .valid_out(c_vo), .illegal(c_ill)
   );

   typedef struct {
      logic       v;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] ctrl;
      logic       ill;
   } vec_t;

   vec_t vecs[$];

   // Reference decode written from the instruction-class rules
   task automatic ref_dec(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, output logic [3:0] ctrl, output logic ill);
      bit         ok = 0;
      int         op = 0;
      logic [7:0] load_ok = 8'b0011_0111;
      int         fn3 = int'(f3);
      case (opc)
         7'h33: begin
            if (f7 == 7'h00) begin ok = 1; op = fn3; end
            else if (f7 == 7'h20 && fn3 == 0) begin ok = 1; op = 8; end
            else if (f7 == 7'h20 && fn3 == 5) begin ok = 1; op = 13; end
         end
         7'h13: begin
            if (fn3 == 1)      begin ok = (f7 == 7'h00); op = 1; end
            else if (fn3 == 5) begin ok = (f7 == 7'h00 || f7 == 7'h20); op = (f7 == 7'h00) ? 5 : 13; end
            else               begin ok = 1; op = fn3; end
         end
         7'h63: begin
            ok = !(fn3 == 2 || fn3 == 3);
            op = (fn3 < 4) ? 8 : ((fn3 < 6) ? 2 : 3);
         end
         7'h03: ok = load_ok[f3];
         7'h23: ok = (fn3 < 3);
         7'h67: ok = (fn3 == 0);
         7'h6f, 7'h17: ok = 1;
         7'h37: begin ok = 1; op = 15; end
         default: ok = 0;
      endcase
      ill  = v && !ok;
      ctrl = (v && ok) ? 4'(op) : 4'd0;
   endtask

   task automatic check(input string nm, input logic [3:0] ac, input logic avo, input logic ai,
                        input logic [3:0] ec, input logic evo, input logic ei);
      n_assert++;
      if (ac !== ec || avo !== evo || ai !== ei) begin
         n_fail++;
         $display("FAIL %s: got ctrl=%b valid_out=%b illegal=%b, expected ctrl=%b valid_out=%b illegal=%b",
                  nm, ac, avo, ai, ec, evo, ei);
      end
   endtask

   // One cycle: drive at negedge, check comb instance, then registered after posedge
   task automatic step(input string nm, input logic rst, input logic v, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [3:0] ec, input logic ei);
      @(negedge clk);
      reset = rst; valid_in = v; opcode = opc; func3 = f3; func7 = f7;
      #1;
      check({nm, "/comb"}, c_ctrl, c_vo, c_ill, ec, v, ei);
      @(posedge clk);
      #1;
      if (rst) check({nm, "/reg"}, r_ctrl, r_vo, r_ill, 4'b0000, 1'b0, 1'b0);
      else     check({nm, "/reg"}, r_ctrl, r_vo, r_ill, ec, v, ei);
   endtask

   initial begin
      logic [3:0] ec;
      logic       ei;
      logic [6:0] opc;
      logic [6:0] f7;
      logic [6:0] opc_pool[10] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23,
                                   7'h67, 7'h6f, 7'h17, 7'h37, 7'h7f};

      reset = 1'b1; valid_in = 1'b1; opcode = 7'h33; func3 = 3'b000; func7 = 7'h20;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", r_ctrl, r_vo, r_ill, 4'b0000, 1'b0, 1'b0);

      vecs.push_back('{1'b1, 7'b0110011, 3'b000, 7'b0100000, 4'b1000, 1'b0}); // SUB
      vecs.push_back('{1'b1, 7'b0010011, 3'b000, 7'b0100000, 4'b0000, 1'b0}); // ADDI f7[5]=1
      vecs.push_back('{1'b1, 7'b0010011, 3'b101, 7'b0100000, 4'b1101, 1'b0}); // SRAI
      vecs.push_back('{1'b1, 7'b0010011, 3'b101, 7'b0000000, 4'b0101, 1'b0}); // SRLI
      vecs.push_back('{1'b1, 7'b0010011, 3'b001, 7'b0100000, 4'b0000, 1'b1}); // bad SLLI
      vecs.push_back('{1'b1, 7'b1100011, 3'b000, 7'b0000000, 4'b1000, 1'b0}); // BEQ
      vecs.push_back('{1'b1, 7'b1100011, 3'b110, 7'b0000000, 4'b0011, 1'b0}); // BLTU
      vecs.push_back('{1'b1, 7'b1100011, 3'b011, 7'b0000000, 4'b0000, 1'b1}); // bad branch
      vecs.push_back('{1'b1, 7'b0000011, 3'b100, 7'b0000000, 4'b0000, 1'b0}); // LBU
      vecs.push_back('{1'b1, 7'b0100011, 3'b100, 7'b0000000, 4'b0000, 1'b1}); // bad store
      vecs.push_back('{1'b1, 7'b0110111, 3'b010, 7'b1010101, 4'b1111, 1'b0}); // LUI
      vecs.push_back('{1'b1, 7'b1111111, 3'b000, 7'b0000000, 4'b0000, 1'b1}); // unknown
      vecs.push_back('{1'b0, 7'b1111111, 3'b000, 7'b0000000, 4'b0000, 1'b0}); // unknown idle
      vecs.push_back('{1'b1, 7'b0110011, 3'b000, 7'b0000001, 4'b0000, 1'b1}); // M-ext
      vecs.push_back('{1'b1, 7'b0110011, 3'b001, 7'b0100000, 4'b0000, 1'b1}); // bad alt
      vecs.push_back('{1'b1, 7'b0110011, 3'b111, 7'b0000000, 4'b0111, 1'b0}); // AND
      vecs.push_back('{1'b1, 7'b0110000, 3'b000, 7'b0000000, 4'b0000, 1'b1}); // low bits 00
      vecs.push_back('{1'b1, 7'b1100111, 3'b001, 7'b0000000, 4'b0000, 1'b1}); // bad JALR
      vecs.push_back('{1'b1, 7'b1101111, 3'b111, 7'b1111111, 4'b0000, 1'b0}); // JAL
      vecs.push_back('{1'b1, 7'b0010111, 3'b011, 7'b0100000, 4'b0000, 1'b0}); // AUIPC
      vecs.push_back('{1'b0, 7'b0110011, 3'b000, 7'b0100000, 4'b0000, 1'b0}); // SUB idle

      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec%0d", i), 1'b0, vecs[i].v, vecs[i].opc, vecs[i].f3, vecs[i].f7,
              vecs[i].ctrl, vecs[i].ill);

      step("b2b_or",   1'b0, 1'b1, 7'b0110011, 3'b110, 7'b0000000, 4'b0110, 1'b0);
      step("b2b_sltu", 1'b0, 1'b1, 7'b0110011, 3'b011, 7'b0000000, 4'b0011, 1'b0);
      step("b2b_sra",  1'b0, 1'b1, 7'b0110011, 3'b101, 7'b0100000, 4'b1101, 1'b0);

      step("mid_rst_in",  1'b1, 1'b1, 7'b0110011, 3'b110, 7'b0000000, 4'b0110, 1'b0);
      step("mid_rst_ill", 1'b1, 1'b1, 7'b1111111, 3'b000, 7'b0000000, 4'b0000, 1'b1);
      step("post_rst",    1'b0, 1'b1, 7'b0010011, 3'b101, 7'b0100000, 4'b1101, 1'b0);

      for (int i = 0; i < 400; i++) begin
         logic       v;
         logic [2:0] f3;
         v   = ($urandom_range(0, 9) != 0);
         opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_pool[$urandom_range(0, 9)];
         f3  = 3'($urandom);
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         ref_dec(v, opc, f3, f7, ec, ei);
         step($sformatf("rand%0d", i), 1'b0, v, opc, f3, f7, ec, ei);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_dec.md
ALU_DEC -- requirements
Module: alu_dec

Interface
REQ-001 Parameter: REG_OUT, default 1, meaning 1 = outputs registered (1-cycle latency), 0 = outputs combinational with clk/reset unused.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_in  input  1  opcode/func3/func7 carry a valid instruction this cycle.
REQ-006 opcode  input  7  instruction bits [6:0].
REQ-007 func3  input  3  instruction bits [14:12].
REQ-008 func7  input  7  instruction bits [31:25].
REQ-009 alu_control  output  4  ALU operation code.
REQ-010 valid_out  output  1  alu_control/illegal are valid.
REQ-011 illegal  output  1  instruction not decodable for the ALU.

Function
REQ-012 Codes SHALL be: ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101, PASSB=1111; the other codes are never driven.
REQ-013 OP (0110011): func7=0000000 -> {0,func3}; func7=0100000 with func3=000 -> SUB, with func3=101 -> SRA; any other func7/func3 combination -> illegal.
REQ-014 OP-IMM (0010011): func3 000/010/011/100/110/111 -> {0,func3}, func7 ignored, so ADDI with func7[5]=1 SHALL give ADD, not SUB.
REQ-015 OP-IMM shifts: func3=001 requires func7=0000000 (SLL); func3=101 with func7=0000000 -> SRL, with 0100000 -> SRA; otherwise illegal.
REQ-016 BRANCH (1100011): func3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> illegal.
REQ-017 LOAD (0000011): func3 000/001/010/100/101 -> ADD; other func3 -> illegal.
REQ-018 STORE (0100011): func3 000/001/010 -> ADD; other func3 -> illegal.
REQ-019 JALR (1100111): func3=000 -> ADD, else illegal; JAL (1101111) and AUIPC (0010111) -> ADD; LUI (0110111) -> PASSB.
REQ-020 Any other opcode (including the low two bits not equal to 11) -> illegal.
REQ-021 When illegal, alu_control SHALL be ADD.
REQ-022 illegal SHALL be asserted only when valid is asserted; if valid_in=0, then illegal=0 and alu_control=ADD.
REQ-023 REG_OUT=1: outputs SHALL be updated on every rising edge from the current inputs; valid_out is valid_in delayed one cycle, and back-to-back valid inputs produce back-to-back outputs with no bubbles.
REQ-024 REG_OUT=0: valid_out=valid_in and all outputs follow the inputs combinationally.
REQ-025 Decoding SHALL be a pure function of the current inputs, with no state other than the output register.

Reset
REQ-026 On a clock edge where reset=1, then alu_control=ADD, valid_out=0 and illegal=0, regardless of the inputs.
REQ-027 If reset is asserted while valid_in=1, that instruction SHALL be dropped; the first output after reset deasserts reflects the inputs sampled on that edge.

Structure
REQ-028 Package alu_pkg SHALL hold the 4-bit ALU op enum (REQ-012) and the opcode constants (OP, OP_IMM, BRANCH, LOAD, STORE, JAL, JALR, LUI, AUIPC).
REQ-029 The block SHALL contain no sub-modules: one combinational decode block plus an optional output register.

Verification
REQ-030 REG_OUT=1: opcode=0110011, func3=000, func7=0100000, valid_in=1 -> next cycle alu_control=1000, illegal=0, valid_out=1.
REQ-031 opcode=0010011, func3=000, func7=0100000 -> alu_control=0000 (ADDI); func3=101, func7=0100000 -> alu_control=1101; func3=001, func7=0100000 -> illegal=1, alu_control=0000.
REQ-032 Branch: func3=000 -> 1000, 110 -> 0011, 011 -> illegal=1; load func3=100 -> 0000; store func3=100 -> illegal=1.
REQ-033 opcode=0110111 -> 1111; opcode=1111111 with valid_in=1 -> illegal=1; the same opcode with valid_in=0 -> illegal=0.
REQ-034 Three back-to-back valid instructions (OR, SLTU, SRA) -> alu_control sequence 0110, 0011, 1101 on three consecutive cycles with valid_out held at 1.
REQ-035 Reset asserted mid-stream -> on the next edge alu_control=0000, valid_out=0, illegal=0; normal decode resumes on the first edge after reset deasserts.
